forwarding_scoreboard: RTL and testbench

- Parametrised successor to the single-entry EX bypass buffer and bypass-ready flag in the current core.
- Keeps a DEPTH-deep, age-ordered history of committed register writebacks and resolves NUM_READ read ports against it, youngest write first.
- Adds a pending-register scoreboard for long-latency ops (loads, future mul/div) and raises a stall while a source register is still in flight.
- Sits between register_file and the ALU operand muxes; the core instantiates it in ID/EX.

---
 rtl/forwarding_scoreboard.sv | 142 ++++++++++++++
 tb/tb_forwarding_scoreboard.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: age-ordered writeback history resolves NUM_READ operand reads,
// and a pending-register vector stalls reads of long-latency destinations still in flight.
module forwarding_scoreboard #(
   parameter int XLEN        = 32,
   parameter int RF_ADDR_LEN = 5,
   parameter int DEPTH       = 2,
   parameter int NUM_READ    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          wb_valid,
   input  logic [RF_ADDR_LEN-1:0]        wb_rd,
   input  logic [XLEN-1:0]               wb_data,
   input  logic                          issue_valid,
   input  logic                          issue_long,
   input  logic [RF_ADDR_LEN-1:0]        issue_rd,
   input  logic [NUM_READ*RF_ADDR_LEN-1:0] rs_addr,
   input  logic [NUM_READ*XLEN-1:0]      rs_data_rf,
   output logic [NUM_READ*XLEN-1:0]      rs_data,
   output logic [NUM_READ-1:0]           rs_fwd,
   output logic                          stall,
   output logic [RF_ADDR_LEN:0]          pending_cnt,
   output logic [31:0]                   stall_cycles
);

   localparam int NREG = 1 << RF_ADDR_LEN;

   logic [DEPTH-1:0]       histValid_q, histValid_d;
   logic [RF_ADDR_LEN-1:0] histRd_q   [DEPTH];
   logic [RF_ADDR_LEN-1:0] histRd_d   [DEPTH];
   logic [XLEN-1:0]        histData_q [DEPTH];
   logic [XLEN-1:0]        histData_d [DEPTH];
   logic [NREG-1:0]        pending_q, pending_d;
   logic [RF_ADDR_LEN:0]   pendCnt_q, pendCnt_d;
   logic [31:0]            stallCycles_q, stallCycles_d;
   logic                   stallComb;

   // Entry i always holds the write committed i+1 cycles ago; x0 writes never become valid.
   always_comb begin
      histValid_d[0] = wb_valid && (wb_rd != '0);
      histRd_d[0]    = wb_rd;
      histData_d[0]  = wb_data;
      for (int i = 1; i < DEPTH; i++) begin
         histValid_d[i] = histValid_q[i-1];
         histRd_d[i]    = histRd_q[i-1];
         histData_d[i]  = histData_q[i-1];
      end
   end

   // A younger issue of the same register outranks its older writeback; flush beats both.
   always_comb begin
      pending_d = pending_q;
      if (flush) begin
         pending_d = '0;
      end else begin
         if (wb_valid)
            pending_d[wb_rd] = 1'b0;
         if (issue_valid && issue_long && (issue_rd != '0))
            pending_d[issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
      pendCnt_d = '0;
      for (int i = 0; i < NREG; i++)
         pendCnt_d = pendCnt_d + (RF_ADDR_LEN+1)'(pending_d[i]);
      stallCycles_d = stallCycles_q;
      if (stallComb && (stallCycles_q != 32'hFFFF_FFFF))
         stallCycles_d = stallCycles_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         histValid_q   <= '0;
         pending_q     <= '0;
         pendCnt_q     <= '0;
         stallCycles_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            histRd_q[i]   <= '0;
            histData_q[i] <= '0;
         end
      end else begin
         histValid_q   <= histValid_d;
         pending_q     <= pending_d;
         pendCnt_q     <= pendCnt_d;
         stallCycles_q <= stallCycles_d;
         for (int i = 0; i < DEPTH; i++) begin
            histRd_q[i]   <= histRd_d[i];
            histData_q[i] <= histData_d[i];
         end
      end
   end

   // History is scanned oldest to youngest so the youngest hit overwrites; wb bus and x0 then override.
   always_comb begin
      logic [RF_ADDR_LEN-1:0] addr;
      logic [XLEN-1:0]        data;
      logic                   fwd;
      logic                   wbHit;
      rs_data   = '0;
      rs_fwd    = '0;
      stallComb = 1'b0;
      addr      = '0;
      data      = '0;
      fwd       = 1'b0;
      wbHit     = 1'b0;
      for (int p = 0; p < NUM_READ; p++) begin
         addr  = rs_addr[p*RF_ADDR_LEN +: RF_ADDR_LEN];
         data  = rs_data_rf[p*XLEN +: XLEN];
         fwd   = 1'b0;
         wbHit = wb_valid && (wb_rd == addr);
         for (int i = DEPTH-1; i >= 0; i--) begin
            if (histValid_q[i] && (histRd_q[i] == addr)) begin
               data = histData_q[i];
               fwd  = 1'b1;
            end
         end
         if (wbHit) begin
            data = wb_data;
            fwd  = 1'b1;
         end
         if (addr == '0) begin
            data = '0;
            fwd  = 1'b0;
         end
         if ((addr != '0) && pending_q[addr] && !wbHit)
            stallComb = 1'b1;
         if (!rst) begin
            data = rs_data_rf[p*XLEN +: XLEN];
            fwd  = 1'b0;
         end
         rs_data[p*XLEN +: XLEN] = data;
         rs_fwd[p]               = fwd;
      end
      if (!rst)
         stallComb = 1'b0;
   end

   assign stall        = stallComb;
   assign pending_cnt  = pendCnt_q;
   assign stall_cycles = stallCycles_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench for forwarding_scoreboard: directed scenarios followed by random
// traffic, all compared against a queue-based history / set-based pending model.
module tb_forwarding_scoreboard;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int DEPTH = 2;
   localparam int NR   = 2;

   logic            clk;
   logic            rst;
   logic            flush;
   logic            wbValid;
   logic [AW-1:0]   wbRd;
   logic [XLEN-1:0] wbData;
   logic            issueValid;
   logic            issueLong;
   logic [AW-1:0]   issueRd;
   logic [NR*AW-1:0]   rsAddr;
   logic [NR*XLEN-1:0] rsDataRf;
   logic [NR*XLEN-1:0] rsData;
   logic [NR-1:0]      rsFwd;
   logic            stall;
   logic [AW:0]     pendingCnt;
   logic [31:0]     stallCycles;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      bit              v;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] d;
   } histEnt_t;

   // Model state: front of the queue is the most recent cycle's commit.
   histEnt_t    hist[$];
   bit          pend[1<<AW];
   int unsigned stallCnt;
   bit          modelStall;

   forwarding_scoreboard #(
      .XLEN(XLEN), .RF_ADDR_LEN(AW), .DEPTH(DEPTH), .NUM_READ(NR)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .wb_valid(wbValid), .wb_rd(wbRd), .wb_data(wbData),
      .issue_valid(issueValid), .issue_long(issueLong), .issue_rd(issueRd),
      .rs_addr(rsAddr), .rs_data_rf(rsDataRf),
      .rs_data(rsData), .rs_fwd(rsFwd), .stall(stall),
      .pending_cnt(pendingCnt), .stall_cycles(stallCycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      hist.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      stallCnt   = 0;
      modelStall = 1'b0;
   endtask

   task automatic setIdle();
      flush      = 1'b0;
      wbValid    = 1'b0;
      wbRd       = '0;
      wbData     = '0;
      issueValid = 1'b0;
      issueLong  = 1'b0;
      issueRd    = '0;
   endtask

   task automatic setRead(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] rf);
      rsAddr[port*AW +: AW]       = a;
      rsDataRf[port*XLEN +: XLEN] = rf;
   endtask

   // Compares every output against the model for the currently driven inputs.
   task automatic checkModel();
      logic [AW-1:0]   a;
      logic [XLEN-1:0] ed;
      bit              ef;
      bit              found;
      int              pc;
      modelStall = 1'b0;
      for (int p = 0; p < NR; p++) begin
         a  = rsAddr[p*AW +: AW];
         ed = rsDataRf[p*XLEN +: XLEN];
         ef = 1'b0;
         found = 1'b0;
         if (a == 0) begin
            ed = '0;
         end else if (wbValid && wbRd == a) begin
            ed = wbData;
            ef = 1'b1;
         end else begin
            foreach (hist[i]) begin
               if (!found && hist[i].v && hist[i].rd == a) begin
                  ed = hist[i].d;
                  ef = 1'b1;
                  found = 1'b1;
               end
            end
         end
         if (a != 0 && pend[a] && !(wbValid && wbRd == a))
            modelStall = 1'b1;
         checkOutput($sformatf("rs_data[%0d]", p), 64'(rsData[p*XLEN +: XLEN]), 64'(ed));
         checkOutput($sformatf("rs_fwd[%0d]", p), 64'(rsFwd[p]), 64'(ef));
      end
      pc = 0;
      foreach (pend[i]) pc += int'(pend[i]);
      checkOutput("stall", 64'(stall), 64'(modelStall));
      checkOutput("pending_cnt", 64'(pendingCnt), 64'(pc));
      checkOutput("stall_cycles", 64'(stallCycles), 64'(stallCnt));
   endtask

   task automatic updateModel();
      histEnt_t e;
      if (modelStall && stallCnt != 32'hFFFF_FFFF)
         stallCnt++;
      e.v  = wbValid && (wbRd != 0);
      e.rd = wbRd;
      e.d  = wbData;
      hist.push_front(e);
      if (hist.size() > DEPTH)
         void'(hist.pop_back());
      if (flush) begin
         foreach (pend[i]) pend[i] = 1'b0;
      end else begin
         if (wbValid) pend[wbRd] = 1'b0;
         if (issueValid && issueLong && issueRd != 0) pend[issueRd] = 1'b1;
      end
   endtask

   // Inputs are driven on the falling edge; outputs settle and are sampled before the rising edge.
   task automatic applyStimulus();
      #1;
      checkModel();
      @(posedge clk);
      updateModel();
      @(negedge clk);
   endtask

   initial begin
      rst      = 1'b0;
      rsAddr   = '0;
      rsDataRf = '0;
      setIdle();
      resetModel();
      setRead(0, 5'd5, 32'h11);
      @(negedge clk);
      #1;
      checkOutput("reset rs_data", 64'(rsData[31:0]), 64'h11);
      checkOutput("reset rs_fwd", 64'(rsFwd), 64'h0);
      checkOutput("reset stall", 64'(stall), 64'h0);
      checkOutput("reset pending_cnt", 64'(pendingCnt), 64'h0);
      @(negedge clk);
      rst = 1'b1;

      // Same-cycle wb forward, then history, then fall back to the register file.
      wbValid = 1'b1; wbRd = 5'd5; wbData = 32'hAA;
      #1;
      checkOutput("wb bypass data", 64'(rsData[31:0]), 64'hAA);
      checkOutput("wb bypass fwd", 64'(rsFwd[0]), 64'h1);
      applyStimulus();
      setIdle();
      #1;
      checkOutput("hist0 data", 64'(rsData[31:0]), 64'hAA);
      applyStimulus();
      applyStimulus();
      #1;
      checkOutput("aged out data", 64'(rsData[31:0]), 64'h11);
      checkOutput("aged out fwd", 64'(rsFwd[0]), 64'h0);
      applyStimulus();

      // Two writes to x7 in back-to-back cycles: youngest must win.
      wbValid = 1'b1; wbRd = 5'd7; wbData = 32'h1;
      applyStimulus();
      wbData = 32'h2;
      applyStimulus();
      setIdle();
      setRead(0, 5'd7, 32'h0);
      #1;
      checkOutput("youngest wins", 64'(rsData[31:0]), 64'h2);
      applyStimulus();

      // Long op to x9 stalls its consumer until the writeback arrives.
      issueValid = 1'b1; issueLong = 1'b1; issueRd = 5'd9;
      applyStimulus();
      setIdle();
      setRead(0, 5'd9, 32'h0);
      #1;
      checkOutput("pending stall", 64'(stall), 64'h1);
      checkOutput("pending count", 64'(pendingCnt), 64'h1);
      applyStimulus();
      wbValid = 1'b1; wbRd = 5'd9; wbData = 32'h55;
      #1;
      checkOutput("wb clears stall", 64'(stall), 64'h0);
      checkOutput("wb resolves data", 64'(rsData[31:0]), 64'h55);
      checkOutput("stall cycles", 64'(stallCycles), 64'h1);
      applyStimulus();
      setIdle();
      #1;
      checkOutput("pending cleared", 64'(pendingCnt), 64'h0);
      applyStimulus();

      // Set and clear of x9 together: the younger issue keeps it pending; flush then drops it.
      wbValid = 1'b1; wbRd = 5'd9; wbData = 32'h66;
      issueValid = 1'b1; issueLong = 1'b1; issueRd = 5'd9;
      applyStimulus();
      setIdle();
      #1;
      checkOutput("set beats clear", 64'(pendingCnt), 64'h1);
      checkOutput("set beats clear stall", 64'(stall), 64'h1);
      flush = 1'b1;
      issueValid = 1'b1; issueLong = 1'b1; issueRd = 5'd12;
      applyStimulus();
      setIdle();
      #1;
      checkOutput("flush count", 64'(pendingCnt), 64'h0);
      checkOutput("flush stall", 64'(stall), 64'h0);
      checkOutput("flush keeps history", 64'(rsData[31:0]), 64'h66);
      applyStimulus();

      // Writes and reads of x0 never forward.
      wbValid = 1'b1; wbRd = 5'd0; wbData = 32'hFF;
      setRead(0, 5'd0, 32'h1234);
      #1;
      checkOutput("x0 data", 64'(rsData[31:0]), 64'h0);
      checkOutput("x0 fwd", 64'(rsFwd[0]), 64'h0);
      applyStimulus();

      for (int n = 0; n < 400; n++) begin
         flush      = ($urandom_range(0, 19) == 0);
         wbValid    = ($urandom_range(0, 1) == 1);
         wbRd       = AW'($urandom_range(0, 7));
         wbData     = $urandom;
         issueValid = ($urandom_range(0, 2) != 0);
         issueLong  = ($urandom_range(0, 2) == 0);
         issueRd    = AW'($urandom_range(0, 7));
         for (int p = 0; p < NR; p++)
            setRead(p, AW'($urandom_range(0, 7)), $urandom);
         applyStimulus();
      end

      // Asynchronous reset while a consumer is stalled.
      setIdle();
      issueValid = 1'b1; issueLong = 1'b1; issueRd = 5'd3;
      applyStimulus();
      setIdle();
      setRead(0, 5'd3, 32'hBEEF);
      setRead(1, 5'd0, 32'h0);
      #1;
      checkOutput("pre-reset stall", 64'(stall), 64'h1);
      #1;
      rst = 1'b0;
      resetModel();
      #1;
      checkOutput("async reset stall", 64'(stall), 64'h0);
      checkOutput("async reset stall_cycles", 64'(stallCycles), 64'h0);
      checkOutput("async reset pending_cnt", 64'(pendingCnt), 64'h0);
      checkOutput("async reset rs_data", 64'(rsData[31:0]), 64'hBEEF);
      checkOutput("async reset rs_fwd", 64'(rsFwd), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
